// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO in front of a uart_tx transmitter. Bytes are pushed with wr_en
//   and handed to the transmitter one at a time through a start/busy
//   handshake. Because tx_busy comes from the slow baud-clock domain, the
//   handshake waits indefinitely in each state.
//
//   Optional feature: define UART_TX_FEEDER_LEVEL_EN to add the `level`
//   output (current FIFO occupancy).
//
// Ports
//   clk      in   system clock, rising edge
//   srst     in   asynchronous active-high reset
//   wr_en    in   push request (ignored when full)
//   wr_data  in   byte to queue
//   full     out  FIFO holds DEPTH entries
//   empty    out  FIFO holds zero entries
//   tx_start out  start request to uart_tx
//   tx_data  out  byte presented to uart_tx
//   tx_busy  in   busy from uart_tx
//   sent     out  one-cycle pulse per completed frame
//   level    out  occupancy (only with UART_TX_FEEDER_LEVEL_EN)
//   idle     out  FSM idle and FIFO empty
module uart_tx_feeder #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  output logic                    full,
  output logic                    empty,
  output logic                    tx_start,
  output logic [7:0]              tx_data,
  input  logic                    tx_busy,
  output logic                    sent,
`ifdef UART_TX_FEEDER_LEVEL_EN
  output logic [$clog2(DEPTH):0]  level,
`endif
  output logic                    idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          sent_q, sent_d;
  logic [7:0]    mem_q [DEPTH];

  logic push;
  logic pop;

  assign full  = (count_q == FULL_COUNT);
  assign empty = (count_q == '0);
  // A push while full is dropped outright, even if a pop frees a slot this cycle.
  assign push  = wr_en && !full;

  // Handshake FSM: pops the head byte and holds it on tx_data until the
  // transmitter acknowledges with tx_busy, then waits for the frame to end.
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    sent_d     = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          pop        = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          sent_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      sent_q     <= sent_d;
    end
  end

  // Storage is not reset; the gate on srst keeps writes during reset out of it.
  always_ff @(posedge clk) begin
    if (push && !srst) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign sent     = sent_q;
  assign idle     = (state_q == IDLE) && empty;

`ifdef UART_TX_FEEDER_LEVEL_EN
  assign level = count_q;
`endif

endmodule
